// File: rtl/risc32_imem.sv
// Instruction memory with one-cycle registered fetch and a byte-serial program loader.
// Optional RISC32_IMEM_BOUNDS_EN: out-of-range fetches return NOP_WORD and raise fault.
module risc32_imem #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        misaligned,
    output logic        fault,
    input  logic        load_start,
    input  logic        load_strobe,
    input  logic [7:0]  load_byte,
    output logic        load_busy,
    output logic        load_done
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(DEPTH - 1);

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [DEPTH_LOG2-1:0] word_ptr_reg;
    logic [DEPTH_LOG2-1:0] word_ptr_next;
    logic [1:0]            byte_cnt_reg;
    logic [1:0]            byte_cnt_next;
    logic [31:0]           asm_reg;
    logic [3:0]            lane_we;

    logic [31:0]           instruction_reg;
    logic                  instr_valid_reg;
    logic                  misaligned_reg;

    logic [31:0]           mem_array [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0] fetch_index;
    logic                  out_of_range;
    logic                  fsm_idle;
    logic                  byte_accept;

    assign fetch_index = address[DEPTH_LOG2+1:2];
    assign fsm_idle    = (state_reg == ST_IDLE);
    // A coincident load_start closes the session, so the strobed byte is dropped.
    assign byte_accept = (state_reg == ST_COLLECT) && load_strobe && !load_start;

`ifdef RISC32_IMEM_BOUNDS_EN
    assign out_of_range = |address[31:DEPTH_LOG2+2];
`else
    logic unused_upper_addr;
    assign unused_upper_addr = ^address[31:DEPTH_LOG2+2];
    assign out_of_range      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        word_ptr_next = word_ptr_reg;
        byte_cnt_next = byte_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    word_ptr_next = '0;
                    byte_cnt_next = 2'd0;
                    state_next    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (load_start) begin
                    state_next = ST_DONE;
                end else if (load_strobe) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_ptr_next = word_ptr_reg + PTR_ONE;
                byte_cnt_next = 2'd0;
                state_next    = (word_ptr_reg == PTR_LAST) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            word_ptr_reg <= '0;
            byte_cnt_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            word_ptr_reg <= word_ptr_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    assign load_busy = (state_reg == ST_COLLECT) || (state_reg == ST_WRITE);
    assign load_done = (state_reg == ST_DONE);

    // ------------------------------------------------------------------
    // Little-endian word assembly: byte count selects the destination lane
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = byte_accept && (byte_cnt_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_reg <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    asm_reg[i*8 +: 8] <= load_byte;
                end
            end
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state_reg == ST_WRITE) begin
            mem_array[word_ptr_reg] <= asm_reg;
        end
    end

    // ------------------------------------------------------------------
    // Fetch port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instruction_reg <= NOP_WORD;
            instr_valid_reg <= 1'b0;
            misaligned_reg  <= 1'b0;
        end else begin
            instr_valid_reg <= fsm_idle;
            if (fsm_idle) begin
                misaligned_reg  <= |address[1:0];
                instruction_reg <= out_of_range ? NOP_WORD : mem_array[fetch_index];
            end else begin
                misaligned_reg  <= 1'b0;
                instruction_reg <= NOP_WORD;
            end
        end
    end

`ifdef RISC32_IMEM_BOUNDS_EN
    logic fault_reg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fsm_idle && out_of_range;
        end
    end
    assign fault = fault_reg;
`else
    assign fault = 1'b0;
`endif

    assign instruction = instruction_reg;
    assign instr_valid = instr_valid_reg;
    assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_risc32_imem.sv
// Directed bench for risc32_imem: a full-size instance plus a 4-word instance for pointer wrap.
module tb_risc32_imem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        instr_valid, misaligned, fault;
    logic        load_start, load_strobe;
    logic [7:0]  load_byte;
    logic        load_busy, load_done;

    logic [31:0] s_address;
    logic [31:0] s_instruction;
    logic        s_instr_valid, s_misaligned, s_fault;
    logic        s_load_start, s_load_strobe;
    logic [7:0]  s_load_byte;
    logic        s_load_busy, s_load_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int s_done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_done)   done_cnt   <= done_cnt + 1;
        if (s_load_done) s_done_cnt <= s_done_cnt + 1;
    end

    risc32_imem #(.DEPTH_LOG2(10), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .instruction(instruction), .instr_valid(instr_valid),
        .misaligned(misaligned), .fault(fault),
        .load_start(load_start), .load_strobe(load_strobe), .load_byte(load_byte),
        .load_busy(load_busy), .load_done(load_done)
    );

    risc32_imem #(.DEPTH_LOG2(2), .NOP_WORD(NOP)) dut_small (
        .clk(clk), .reset_n(reset_n), .address(s_address),
        .instruction(s_instruction), .instr_valid(s_instr_valid),
        .misaligned(s_misaligned), .fault(s_fault),
        .load_start(s_load_start), .load_strobe(s_load_strobe), .load_byte(s_load_byte),
        .load_busy(s_load_busy), .load_done(s_load_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_strobe = 1'b1;
        load_byte   = b;
        step();
        load_strobe = 1'b0;
    endtask

    // Four bytes little-endian, then one idle cycle for the WRITE state.
    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
        step();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        address = a;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        address = 32'd0; load_start = 1'b0; load_strobe = 1'b0; load_byte = 8'd0;
        s_address = 32'd0; s_load_start = 1'b0; s_load_strobe = 1'b0; s_load_byte = 8'd0;
        step(); step();
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instruction: got %h expected %h", instruction, NOP); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (load_busy !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL reset_load_flags: busy %b done %b expected 0 0", load_busy, load_done); end
        reset_n = 1'b1;
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b expected 1", instr_valid); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL release_misaligned: got %b expected 0", misaligned); end
        $display("test_reset done");
    endtask

    task automatic test_load_basic();
        int d0;
        d0 = done_cnt;
        address = 32'd6;
        pulse_start();
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", load_busy); end
        checks++; if (instr_valid !== 1'b1 || misaligned !== 1'b1) begin errors++; $display("FAIL idle_fetch_at_start: valid %b mis %b expected 1 1", instr_valid, misaligned); end
        send_byte(8'h78);
        checks++; if (instruction !== NOP || instr_valid !== 1'b0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL collect_outputs: instr %h valid %b mis %b expected %h 0 0", instruction, instr_valid, misaligned, NOP);
        end
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        step();
        send_word(32'hCAFE_BABE);
        pulse_start();
        checks++; if (load_done !== 1'b1 || load_busy !== 1'b0) begin errors++; $display("FAIL end_done: done %b busy %b expected 1 0", load_done, load_busy); end
        step();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", load_done); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL done_pulse_count: got %0d expected 1", done_cnt - d0); end
        fetch(32'd0);
        checks++; if (instruction !== 32'h1234_5678 || instr_valid !== 1'b1) begin errors++; $display("FAIL read_word0: got %h valid %b expected 12345678 1", instruction, instr_valid); end
        fetch(32'd4);
        checks++; if (instruction !== 32'hCAFE_BABE) begin errors++; $display("FAIL read_word1: got %h expected cafebabe", instruction); end
        $display("test_load_basic done");
    endtask

    task automatic test_partial();
        int d0;
        d0 = done_cnt;
        pulse_start();
        send_word(32'hA1B2_C3D4);
        send_byte(8'hEE);
        pulse_start();
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL partial_done: got %b expected 1", load_done); end
        step();
        fetch(32'd0);
        checks++; if (instruction !== 32'hA1B2_C3D4) begin errors++; $display("FAIL partial_word0: got %h expected a1b2c3d4", instruction); end
        fetch(32'd4);
        checks++; if (instruction !== 32'hCAFE_BABE) begin errors++; $display("FAIL partial_word1_kept: got %h expected cafebabe", instruction); end
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        load_start = 1'b1; load_strobe = 1'b1; load_byte = 8'h44;
        step();
        load_start = 1'b0; load_strobe = 1'b0;
        checks++; if (load_done !== 1'b1 || load_busy !== 1'b0) begin errors++; $display("FAIL coincident_done: done %b busy %b expected 1 0", load_done, load_busy); end
        step(); step();
        fetch(32'd0);
        checks++; if (instruction !== 32'hA1B2_C3D4) begin errors++; $display("FAIL coincident_no_write: got %h expected a1b2c3d4", instruction); end
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL partial_done_count: got %0d expected 2", done_cnt - d0); end
        $display("test_partial done");
    endtask

    task automatic test_misaligned();
        fetch(32'd6);
        checks++; if (misaligned !== 1'b1 || instruction !== 32'hCAFE_BABE) begin errors++; $display("FAIL mis_addr6: mis %b instr %h expected 1 cafebabe", misaligned, instruction); end
        fetch(32'd3);
        checks++; if (misaligned !== 1'b1 || instruction !== 32'hA1B2_C3D4) begin errors++; $display("FAIL mis_addr3: mis %b instr %h expected 1 a1b2c3d4", misaligned, instruction); end
        fetch(32'd4);
        checks++; if (misaligned !== 1'b0 || instruction !== 32'hCAFE_BABE) begin errors++; $display("FAIL aligned_addr4: mis %b instr %h expected 0 cafebabe", misaligned, instruction); end
        $display("test_misaligned done");
    endtask

    task automatic test_bounds();
        fetch(32'h0000_1000);
`ifdef RISC32_IMEM_BOUNDS_EN
        checks++; if (instruction !== NOP || fault !== 1'b1) begin errors++; $display("FAIL bounds_1000: instr %h fault %b expected %h 1", instruction, fault, NOP); end
`else
        checks++; if (instruction !== 32'hA1B2_C3D4 || fault !== 1'b0) begin errors++; $display("FAIL wrap_1000: instr %h fault %b expected a1b2c3d4 0", instruction, fault); end
`endif
        fetch(32'h0000_0004);
        checks++; if (fault !== 1'b0 || instruction !== 32'hCAFE_BABE) begin errors++; $display("FAIL inrange_after_bounds: instr %h fault %b expected cafebabe 0", instruction, fault); end
        $display("test_bounds done");
    endtask

    task automatic test_auto_wrap();
        logic [31:0] exp_words [4];
        int d0;
        exp_words[0] = 32'h0403_0201; exp_words[1] = 32'h1413_1211;
        exp_words[2] = 32'h2423_2221; exp_words[3] = 32'h3433_3231;
        d0 = s_done_cnt;
        s_load_start = 1'b1; step(); s_load_start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                s_load_strobe = 1'b1;
                s_load_byte   = 8'(w * 16 + j + 1);
                step();
                s_load_strobe = 1'b0;
            end
            if (w < 3) step();
        end
        step();
        checks++; if (s_load_done !== 1'b1) begin errors++; $display("FAIL wrap_auto_done: got %b expected 1", s_load_done); end
        step();
        checks++; if (s_load_done !== 1'b0 || s_load_busy !== 1'b0) begin errors++; $display("FAIL wrap_back_idle: done %b busy %b expected 0 0", s_load_done, s_load_busy); end
        checks++; if (s_done_cnt - d0 !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d expected 1", s_done_cnt - d0); end
        for (int w = 0; w < 4; w++) begin
            s_address = 32'(w * 4);
            step();
            checks++; if (s_instruction !== exp_words[w]) begin errors++; $display("FAIL wrap_word%0d: got %h expected %h", w, s_instruction, exp_words[w]); end
        end
`ifndef RISC32_IMEM_BOUNDS_EN
        s_address = 32'd16;
        step();
        checks++; if (s_instruction !== exp_words[0]) begin errors++; $display("FAIL small_index_wrap: got %h expected %h", s_instruction, exp_words[0]); end
`endif
        $display("test_auto_wrap done");
    endtask

    task automatic test_reset_midload();
        int d0;
        d0 = done_cnt;
        pulse_start();
        send_word(32'h0102_0304);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (load_busy !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL midload_reset_flags: busy %b done %b expected 0 0", load_busy, load_done); end
        checks++; if (instruction !== NOP || instr_valid !== 1'b0) begin errors++; $display("FAIL midload_reset_fetch: instr %h valid %b expected %h 0", instruction, instr_valid, NOP); end
        step(); step();
        reset_n = 1'b1;
        fetch(32'd0);
        checks++; if (instruction !== 32'h0102_0304) begin errors++; $display("FAIL midload_word0_kept: got %h expected 01020304", instruction); end
        fetch(32'd4);
        checks++; if (instruction !== 32'hCAFE_BABE) begin errors++; $display("FAIL midload_word1_unwritten: got %h expected cafebabe", instruction); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midload_no_done: got %0d pulses expected 0", done_cnt - d0); end
        $display("test_reset_midload done");
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_partial();
        test_misaligned();
        test_bounds();
        test_auto_wrap();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc32_imem.md
RISC32_IMEM -- requirements
Module: risc32_imem

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set memory depth to 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, SHALL be the word driven when no valid instruction is available.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 address  input  32  byte address of fetch, driven by core PC.
REQ-006 instruction  output  32  registered fetched word.
REQ-007 instr_valid  output  1  instruction holds a fetch result from the previous cycle's address.
REQ-008 misaligned  output  1  registered flag; address[1:0] was nonzero at the fetch.
REQ-009 fault  output  1  registered out-of-range flag (see Configuration).
REQ-010 load_start  input  1  begin load session, or end an active one.
REQ-011 load_strobe  input  1  load_byte valid this cycle.
REQ-012 load_byte  input  8  program byte.
REQ-013 load_busy  output  1  load session active.
REQ-014 load_done  output  1  one-cycle pulse when a load session ends.

Function
REQ-015 Fetch SHALL have one-cycle latency: instruction <= mem[address[DEPTH_LOG2+1:2]] each cycle while not loading.
REQ-016 instr_valid SHALL be 1 in any cycle whose preceding cycle had load FSM in IDLE, else 0.
REQ-017 misaligned SHALL register (address[1:0] != 0); the word fetched SHALL still use the truncated word index.
REQ-018 Loader FSM states SHALL be IDLE, COLLECT, WRITE, DONE; load_busy = 1 in COLLECT and WRITE.
REQ-019 IDLE: load_start SHALL clear word pointer and byte count to 0 and go to COLLECT; load_strobe in IDLE SHALL be ignored.
REQ-020 COLLECT: each load_strobe SHALL place load_byte little-endian (first byte -> bits 7:0) into the assembly register and increment byte count; the fourth byte SHALL go to WRITE.
REQ-021 WRITE: the assembled word SHALL be written at the word pointer, the pointer incremented, byte count cleared; next state COLLECT, or DONE if the pointer wrapped from 2^DEPTH_LOG2-1 to 0.
REQ-022 load_start in COLLECT SHALL go to DONE and discard partial bytes; if load_strobe coincides, load_start wins and the byte is discarded.
REQ-023 load_start and load_strobe in WRITE and DONE SHALL be ignored.
REQ-024 DONE SHALL assert load_done for exactly one cycle and return to IDLE.
REQ-025 While FSM is not IDLE, instruction SHALL be NOP_WORD, and misaligned and fault SHALL be 0.

Reset
REQ-026 On reset_n low: instruction = NOP_WORD, instr_valid = 0, misaligned = 0, fault = 0, load_busy = 0, load_done = 0, FSM = IDLE, pointer = 0, byte count = 0.
REQ-027 Reset mid-load SHALL abort the session without load_done; words already written SHALL remain; memory array SHALL NOT be reset.

Configuration
REQ-028 With RISC32_IMEM_BOUNDS_EN defined, a fetch with address[31:DEPTH_LOG2+2] != 0 SHALL return NOP_WORD and register fault = 1.
REQ-029 Without RISC32_IMEM_BOUNDS_EN, upper address bits SHALL be ignored (index wraps), and fault SHALL be tied 0.

Verification
REQ-030 Reset release, address=0, no load -> instr_valid=1 next cycle, instruction = mem[0], misaligned=0.
REQ-031 load_start, bytes 78,56,34,12, then load_start -> mem[0]=32'h12345678; load_done pulses once; address=0 then reads 32'h12345678 one cycle later.
REQ-032 Load with 5 bytes then load_start -> only word 0 written, fifth byte discarded; load_start coincident with a strobe -> byte dropped.
REQ-033 DEPTH_LOG2=2, 16 bytes streamed -> auto DONE after word 3 with no load_start; load_done=1 for one cycle.
REQ-034 address=32'h0000_0006 -> misaligned=1, instruction = mem[1]; with RISC32_IMEM_BOUNDS_EN and DEPTH_LOG2=10, address=32'h1000 -> instruction=NOP_WORD, fault=1; without it -> mem[0], fault=0.
REQ-035 reset_n low after 2 of 4 bytes of word 1 -> load_busy=0 immediately, no load_done, word 0 intact.
